// File: rtl/axis_subcarrier_mixer_if.sv
// Multi-lane AXI-Stream bundle. LANES parallel streams share one set of
// wires; lane i occupies slice i of tdata/tstrb and bit i of the scalars.
interface axis_subcarrier_mixer_if #(
    parameter int LANES       = 1,
    parameter int TDATA_WIDTH = 32
);
    logic [LANES*TDATA_WIDTH-1:0]   tdata;
    logic [LANES-1:0]               tvalid;
    logic [LANES-1:0]               tlast;
    logic [LANES*TDATA_WIDTH/8-1:0] tstrb;
    logic [LANES-1:0]               tready;

    modport master (output tdata, output tvalid, output tlast, output tstrb, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tstrb, output tready);
endinterface

// File: rtl/axis_subcarrier_mixer.sv
// N-channel AXI-Stream mixer: joins one sample per enabled channel, applies
// a per-channel unsigned gain, sums with round-half-up and saturation, and
// buffers the result in a small FIFO toward the DAC path.
//
// Handshake semantics (both sides): a beat transfers on a rising edge where
// tvalid & tready are both high; a source never withdraws or changes a beat
// while tvalid is high and tready is low, and tready may depend on tvalid.
module axis_subcarrier_mixer #(
    parameter int NUM_CH       = 3,
    parameter int TDATA_WIDTH  = 32,
    parameter int SAMPLE_WIDTH = 16,
    parameter int GAIN_WIDTH   = 8,
    parameter int GAIN_FRAC    = 7,
    parameter int OUT_WIDTH    = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         s00_axis_aclk,
    input  logic                         s00_axis_areset,
    axis_subcarrier_mixer_if.slave       s00_axis,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH*GAIN_WIDTH-1:0] ch_gain,
    axis_subcarrier_mixer_if.master      m00_axis,
    output logic [15:0]                  sat_count
);
    localparam int PROD_W = SAMPLE_WIDTH + GAIN_WIDTH + 1;
    localparam int SUM_W  = PROD_W + $clog2(NUM_CH);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int INF_W  = CNT_W + 1;

    localparam logic signed [SUM_W-1:0] OUT_MAX =
        {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OUT_MIN =
        {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] ROUND_HALF = SUM_W'(2 ** (GAIN_FRAC - 1));

    logic clk;
    logic rst;
    assign clk = s00_axis_aclk;
    assign rst = s00_axis_areset;

    // Pipeline / FIFO state
    logic                      s1_valid;
    logic                      s1_last;
    logic signed [PROD_W-1:0]  s1_prod [NUM_CH];
    logic                      s2_valid;
    logic                      s2_last;
    logic [OUT_WIDTH-1:0]      s2_data;
    logic [15:0]               sat_q;
    logic [OUT_WIDTH:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          fifo_count;

    // Combinational helpers
    logic [INF_W-1:0]          inflight;
    logic                      credit_ok;
    logic                      all_valid;
    logic                      fire;
    logic signed [PROD_W-1:0]  prod [NUM_CH];
    logic signed [SUM_W-1:0]   acc;
    logic signed [SUM_W-1:0]   shifted;
    logic                      clamp;
    logic [OUT_WIDTH-1:0]      sat_val;
    logic                      push;
    logic                      pop;
    logic [OUT_WIDTH:0]        head;

    // Credit-gated join: every enabled channel must be valid and the samples
    // already committed downstream must leave a free FIFO slot.
    always_comb begin
        inflight  = INF_W'(fifo_count) + INF_W'(s1_valid) + INF_W'(s2_valid);
        credit_ok = inflight < INF_W'(FIFO_DEPTH);
        all_valid = &(s00_axis.tvalid | ~ch_enable);
        fire      = !rst && credit_ok && (ch_enable != '0) && all_valid;
        s00_axis.tready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s00_axis.tready[i] = rst ? 1'b0 : (ch_enable[i] ? fire : 1'b1);
        end
    end

    // Per-channel gain products; disabled channels contribute zero.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            prod[i] = '0;
            if (ch_enable[i]) begin
                prod[i] = PROD_W'($signed(s00_axis.tdata[i*TDATA_WIDTH +: SAMPLE_WIDTH]))
                        * PROD_W'($signed({1'b0, ch_gain[i*GAIN_WIDTH +: GAIN_WIDTH]}));
            end
        end
    end

    // Stage 1: capture products and channel-0 tlast on the fire edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) s1_prod[i] <= '0;
        end else begin
            s1_valid <= fire;
            if (fire) begin
                s1_last <= s00_axis.tlast[0];
                for (int i = 0; i < NUM_CH; i++) s1_prod[i] <= prod[i];
            end
        end
    end

    // Sum, round half up, and clamp to the signed output range.
    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_CH; i++) acc = acc + SUM_W'(s1_prod[i]);
        shifted = (acc + ROUND_HALF) >>> GAIN_FRAC;
        clamp   = 1'b0;
        sat_val = shifted[OUT_WIDTH-1:0];
        if (shifted > OUT_MAX) begin
            clamp   = 1'b1;
            sat_val = OUT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < OUT_MIN) begin
            clamp   = 1'b1;
            sat_val = OUT_MIN[OUT_WIDTH-1:0];
        end
    end

    // Stage 2: register the mixed sample and count clamps (sticky at max).
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
            sat_q    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_last;
                s2_data <= sat_val;
                if (clamp && sat_q != 16'hFFFF) sat_q <= sat_q + 16'd1;
            end
        end
    end

    assign push = s2_valid;
    assign pop  = (fifo_count != '0) && m00_axis.tready[0];
    assign head = fifo_mem[rd_ptr];

    // FIFO storage; credit accounting guarantees a free slot on every push.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {s2_last, s2_data};
    end

    // FIFO pointers and occupancy; simultaneous push and pop are allowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Output side: head of FIFO, forced to zero while reset is held.
    always_comb begin
        m00_axis.tvalid = (!rst && fifo_count != '0);
        m00_axis.tlast  = m00_axis.tvalid ? head[OUT_WIDTH] : 1'b0;
        m00_axis.tdata  = m00_axis.tvalid ? TDATA_WIDTH'($signed(head[OUT_WIDTH-1:0])) : '0;
        m00_axis.tstrb  = '1;
        sat_count       = rst ? 16'h0000 : sat_q;
    end

    // Strobes, upper tdata bits and tlast of channels above 0 carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{s00_axis.tstrb, s00_axis.tdata, s00_axis.tlast};

endmodule

// File: tb/tb_axis_subcarrier_mixer.sv
// Directed bench for axis_subcarrier_mixer: hand-computed vectors, an
// expected queue compared against outputs captured on the falling edge.
module tb_axis_subcarrier_mixer;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ch_enable;
    logic [23:0] ch_gain;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;
    int str_k;
    int str_base;

    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];

    axis_subcarrier_mixer_if #(.LANES(3), .TDATA_WIDTH(32)) s_if ();
    axis_subcarrier_mixer_if #(.LANES(1), .TDATA_WIDTH(32)) m_if ();

    axis_subcarrier_mixer dut (
        .s00_axis_aclk  (clk),
        .s00_axis_areset(rst),
        .s00_axis       (s_if),
        .ch_enable      (ch_enable),
        .ch_gain        (ch_gain),
        .m00_axis       (m_if),
        .sat_count      (sat_count)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // output capture: one accepted beat per falling edge with valid & ready
    always @(negedge clk) begin
        if (!rst && m_if.tvalid[0] && m_if.tready[0])
            obs_q.push_back({m_if.tlast[0], m_if.tdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // one joined beat on the enabled channels; bounded wait for the handshake
    task automatic send(input logic [2:0] en, input logic [23:0] gains,
                        input logic signed [15:0] d0, input logic signed [15:0] d1,
                        input logic signed [15:0] d2, input logic last);
        logic hs;
        int   n;
        ch_enable    = en;
        ch_gain      = gains;
        s_if.tdata   = {16'h1234, d2, 16'h1234, d1, 16'h1234, d0};
        s_if.tlast   = {2'b00, last};
        s_if.tvalid  = en;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 50) begin
            #1;
            hs = |(s_if.tready & en);
            tick();
            n++;
        end
        check("send_handshake", 64'(hs), 64'd1);
        s_if.tvalid = 3'b000;
    endtask

    // continuous channel-0 stream; advances the sample only on handshake
    task automatic stream(input int target, input int max_cyc);
        logic hs;
        int   n;
        n = 0;
        while (str_k < target && n < max_cyc) begin
            s_if.tdata[31:0] = {16'h5A5A, 16'(str_base + str_k)};
            s_if.tlast[0]    = (str_k % 3 == 2);
            s_if.tvalid[0]   = 1'b1;
            #1;
            hs = s_if.tready[0];
            tick();
            if (hs) str_k++;
            n++;
        end
        if (str_k >= target) s_if.tvalid[0] = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int c;
        c = 0;
        while (obs_q.size() < n && c < 200) begin
            tick();
            c++;
        end
        check("out_count", 64'(obs_q.size()), 64'(n));
    endtask

    task automatic compare_exp(input string tag);
        logic [32:0] e;
        logic [32:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            else o = 'x;
            check(tag, 64'(o), 64'(e));
        end
    endtask

    initial begin
        logic [32:0] first;
        rst          = 1'b1;
        ch_enable    = 3'b001;
        ch_gain      = '0;
        s_if.tdata   = '0;
        s_if.tvalid  = '0;
        s_if.tlast   = '0;
        s_if.tstrb   = '0;
        m_if.tready  = 1'b1;
        str_k        = 0;
        str_base     = 0;

        // reset state
        repeat (3) tick();
        check("rst_tready", 64'(s_if.tready), 64'd0);
        check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_tlast", 64'(m_if.tlast), 64'd0);
        check("rst_tdata", 64'(m_if.tdata), 64'd0);
        check("rst_sat", 64'(sat_count), 64'd0);
        rst = 1'b0;
        tick();

        // single channel, latency and strobe
        send(3'b001, 24'h000080, 16'sd1000, 16'sd0, 16'sd0, 1'b0);
        check("lat_cycle1", 64'(m_if.tvalid), 64'd0);
        tick();
        check("lat_cycle2", 64'(m_if.tvalid), 64'd0);
        tick();
        check("lat_cycle3", 64'(m_if.tvalid), 64'd1);
        check("tstrb", 64'(m_if.tstrb), 64'hF);
        send(3'b001, 24'h000080, -16'sd1000, 16'sd0, 16'sd0, 1'b0);
        exp_q.push_back({1'b0, 32'h000003E8});
        exp_q.push_back({1'b0, 32'hFFFFFC18});
        wait_out(2);
        compare_exp("single_ch");

        // three-channel sum and rounding
        send(3'b111, 24'h804080, 16'sd1000, 16'sd2000, -16'sd500, 1'b1);
        send(3'b001, 24'h000040, 16'sd3, 16'sd0, 16'sd0, 1'b0);
        send(3'b001, 24'h000040, -16'sd3, 16'sd0, 16'sd0, 1'b0);
        exp_q.push_back({1'b1, 32'd1500});
        exp_q.push_back({1'b0, 32'd2});
        exp_q.push_back({1'b0, 32'hFFFFFFFF});
        wait_out(3);
        compare_exp("three_ch");
        check("sat_none", 64'(sat_count), 64'd0);

        // saturation
        send(3'b011, 24'h008080, 16'sd30000, 16'sd30000, 16'sd0, 1'b0);
        exp_q.push_back({1'b0, 32'h00007FFF});
        wait_out(1);
        compare_exp("sat_pos");
        check("sat_count1", 64'(sat_count), 64'd1);
        send(3'b011, 24'h008080, -16'sd32768, -16'sd32768, 16'sd0, 1'b0);
        exp_q.push_back({1'b0, 32'hFFFF8000});
        wait_out(1);
        compare_exp("sat_neg");
        check("sat_count2", 64'(sat_count), 64'd2);

        ch_enable      = 3'b001;
        ch_gain        = 24'h0000FF;
        s_if.tdata     = {64'h0, 16'h0000, 16'h7FFF};
        s_if.tlast     = 3'b000;
        s_if.tvalid    = 3'b001;
        repeat (65540) tick();
        s_if.tvalid    = 3'b000;
        repeat (10) tick();
        check("sat_sticky", 64'(sat_count), 64'hFFFF);
        check("sat_burst_count", 64'(obs_q.size()), 64'd65540);
        first = (obs_q.size() > 0) ? obs_q[0] : 33'h1_FFFF_FFFF;
        check("sat_burst_value", 64'(first), 64'h0000_7FFF);
        obs_q.delete();

        // join with skew; ch2 disabled and drained
        ch_enable   = 3'b011;
        ch_gain     = 24'h808080;
        s_if.tdata  = {16'h0, 16'sd5, 16'h0, 16'sd200, 16'h0, 16'sd100};
        s_if.tlast  = 3'b000;
        s_if.tvalid = 3'b101;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("skew_wait_ready", 64'(s_if.tready), 64'b100);
            tick();
        end
        s_if.tvalid = 3'b111;
        #1;
        check("skew_fire_ready", 64'(s_if.tready), 64'b111);
        tick();
        s_if.tvalid = 3'b000;
        exp_q.push_back({1'b0, 32'd300});
        wait_out(1);
        repeat (5) tick();
        check("skew_one_output", 64'(obs_q.size()), 64'd1);
        compare_exp("skew_sum");

        // all channels disabled: everything drained, nothing produced
        ch_enable   = 3'b000;
        s_if.tvalid = 3'b111;
        #1;
        check("none_ready", 64'(s_if.tready), 64'b111);
        repeat (6) tick();
        s_if.tvalid = 3'b000;
        check("none_output", 64'(obs_q.size()), 64'd0);

        // backpressure: four samples buffered, then release in order
        ch_enable   = 3'b001;
        ch_gain     = 24'h000080;
        m_if.tready = 1'b0;
        str_base    = 10;
        str_k       = 0;
        stream(8, 10);
        check("bp_accepted", 64'(str_k), 64'd4);
        #1;
        check("bp_tready", 64'(s_if.tready[0]), 64'd0);
        check("bp_tvalid", 64'(m_if.tvalid), 64'd1);
        check("bp_no_output", 64'(obs_q.size()), 64'd0);
        m_if.tready = 1'b1;
        stream(8, 60);
        check("bp_total", 64'(str_k), 64'd8);
        for (int k = 0; k < 8; k++) exp_q.push_back({(k % 3 == 2), 32'(10 + k)});
        wait_out(8);
        compare_exp("bp_order");

        // reset with samples in flight
        str_base = 40;
        str_k    = 0;
        stream(3, 20);
        rst = 1'b1;
        #1;
        check("mid_rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("mid_rst_tready", 64'(s_if.tready), 64'd0);
        tick();
        check("mid_rst_tdata", 64'(m_if.tdata), 64'd0);
        check("mid_rst_tlast", 64'(m_if.tlast), 64'd0);
        check("mid_rst_sat", 64'(sat_count), 64'd0);
        rst = 1'b0;
        tick();
        check("mid_rst_dropped", 64'(obs_q.size()), 64'd0);
        send(3'b001, 24'h000080, 16'sd77, 16'sd0, 16'sd0, 1'b1);
        exp_q.push_back({1'b1, 32'd77});
        wait_out(1);
        repeat (5) tick();
        check("post_rst_count", 64'(obs_q.size()), 64'd1);
        compare_exp("post_rst_first");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
